dm_sync_handshake: RTL and testbench

- Parametrised data memory for the pipelined CPU's MEM stage. Successor to the single-cycle combinational DM.
- Adds a registered, configurable-latency request/response handshake, byte/halfword lane writes with a byte-enable path, and sign/zero load extension.
- Adds alignment, range and opcode checking with an error response.
- The CPU stalls MEM while a request is outstanding. One request in flight at a time.

---
 rtl/dm_sync_handshake.sv | 131 +++++++++++++
 tb/tb_dm_sync_handshake.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sync_handshake.sv
// Data memory for the MEM stage: one request in flight, fixed-latency
// registered response, byte/halfword lanes, load extension, error response.
module dm_sync_handshake #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [63:0] SPAN = 64'(DEPTH) << 2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_B  = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;

  logic [31:0] mem [DEPTH];

  logic        busy;
  logic [3:0]  cnt;
  logic        c_we;
  logic [2:0]  c_op;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;

  logic                  done;
  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           word;
  logic [15:0]           half;
  logic [7:0]            byt;
  logic                  oor;
  logic                  bad_op;
  logic                  misalign;
  logic                  err;
  logic [3:0]            be;
  logic [31:0]           wd;
  logic [31:0]           ld;

  assign req_ready = ~busy;
  assign done      = busy && (cnt == 4'd0);

  // Below-base addresses wrap high in the subtraction and fail the range test.
  assign off  = c_addr - BASE_ADDR;
  assign idx  = off[ADDR_WIDTH+1:2];
  assign oor  = {32'd0, off} >= SPAN;
  assign word = mem[idx];
  assign half = c_addr[1] ? word[31:16] : word[15:0];
  assign byt  = word[{c_addr[1:0], 3'b000} +: 8];

  always_comb begin
    bad_op   = 1'b0;
    misalign = 1'b0;
    be       = 4'b0000;
    wd       = c_wdata;
    ld       = word;
    unique case (c_op)
      OP_W: begin
        misalign = c_addr[1:0] != 2'b00;
        be       = 4'b1111;
      end
      OP_H, OP_HU: begin
        misalign = c_addr[0];
        be       = c_addr[1] ? 4'b1100 : 4'b0011;
        wd       = {2{c_wdata[15:0]}};
        ld       = (c_op == OP_H) ? {{16{half[15]}}, half}
                                  : {16'd0, half};
      end
      OP_B, OP_BU: begin
        be = 4'b0001 << c_addr[1:0];
        wd = {4{c_wdata[7:0]}};
        ld = (c_op == OP_B) ? {{24{byt[7]}}, byt}
                            : {24'd0, byt};
      end
      default: bad_op = 1'b1;
    endcase
    err = bad_op | misalign | oor;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      busy       <= 1'b0;
      cnt        <= '0;
      c_we       <= 1'b0;
      c_op       <= '0;
      c_addr     <= '0;
      c_wdata    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (done) begin
        busy       <= 1'b0;
        resp_valid <= 1'b1;
        resp_err   <= err;
        resp_rdata <= (err || c_we) ? '0 : ld;
        if (!err && c_we)
          for (int k = 0; k < 4; k++)
            if (be[k])
              mem[idx][8*k +: 8] <= wd[8*k +: 8];
      end else if (busy) begin
        cnt <= cnt - 4'd1;
      end else if (req_valid) begin
        busy    <= 1'b1;
        cnt     <= CNT_INIT;
        c_we    <= req_we;
        c_op    <= req_op;
        c_addr  <= req_addr;
        c_wdata <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_sync_handshake.sv
// Bench for dm_sync_handshake: three instances (latency 1, 4 with base
// 0x1000, 3) checked against a byte-level memory model.
module tb_dm_sync_handshake;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  int          sel;
  logic [2:0]  rdy;
  logic [2:0]  rvld;
  logic [2:0]  rerr;
  logic [31:0] rdat0, rdat1, rdat2;

  int n_checks = 0;
  int n_fail   = 0;

  bit [31:0] mdl [int];
  int        lat  [3] = '{1, 4, 3};
  bit [31:0] base [3] = '{32'h0, 32'h1000, 32'h0};

  dm_sync_handshake #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(1)) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel == 0),
    .req_ready(rdy[0]), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvld[0]),
    .resp_rdata(rdat0), .resp_err(rerr[0]));

  dm_sync_handshake #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1000), .LATENCY(4)) u_b (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel == 1),
    .req_ready(rdy[1]), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvld[1]),
    .resp_rdata(rdat1), .resp_err(rerr[1]));

  dm_sync_handshake #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(3)) u_c (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel == 2),
    .req_ready(rdy[2]), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvld[2]),
    .resp_rdata(rdat2), .resp_err(rerr[2]));

  always #5 clk = ~clk;

  function automatic logic [31:0] rdat(input int d);
    case (d)
      0:       return rdat0;
      1:       return rdat1;
      default: return rdat2;
    endcase
  endfunction

  // Byte-addressed reference: size from op, lanes walked one byte at a time.
  function automatic void model(input int d, input bit we, input bit [2:0] op,
                                input bit [31:0] addr, input bit [31:0] wd,
                                output bit err, output bit [31:0] rd);
    bit [31:0] off, word, v;
    int size, key, lane;
    off  = addr - base[d];
    size = (op == 0) ? 4 : (op <= 2) ? 2 : 1;
    err  = (op > 4) || (addr % size != 0) || (off >= 32'd4096);
    rd   = 0;
    if (err) return;
    key  = d * 4096 + int'(off / 4);
    word = mdl.exists(key) ? mdl[key] : 32'h0;
    v    = 0;
    for (int b = 0; b < size; b++) begin
      lane = int'(addr % 4) + b;
      if (we)
        word = (word & ~(32'hFF << (8*lane)))
             | (((wd >> (8*b)) & 32'hFF) << (8*lane));
      else
        v |= ((word >> (8*lane)) & 32'hFF) << (8*b);
    end
    if (we) begin
      mdl[key] = word;
    end else begin
      if ((op == 1 || op == 3) && size < 4 && v[8*size-1])
        v |= 32'hFFFF_FFFF << (8*size);
      rd = v;
    end
  endfunction

  task automatic access(input int d, input bit we, input bit [2:0] op,
                        input bit [31:0] addr, input bit [31:0] wd,
                        input string nm,
                        output bit [31:0] got_rd, output bit got_err);
    bit e_err;
    bit [31:0] e_rd;
    int j, low;
    model(d, we, op, addr, wd, e_err, e_rd);
    sel = d;
    req_valid = 1; req_we = we; req_op = op;
    req_addr = addr; req_wdata = wd;
    n_checks++;
    if (rdy[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready: got %b want 1", nm, rdy[d]);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    req_op = 3'($urandom_range(0, 7)); req_we = 1'($urandom_range(0, 1));
    j = 0; low = 0;
    while (rvld[d] !== 1'b1 && j < 40) begin
      if (rdy[d] !== 1'b1) low++;
      @(negedge clk);
      j++;
    end
    got_rd = rdat(d); got_err = rerr[d];
    n_checks++;
    if (j != lat[d]) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", nm, j, lat[d]);
    end
    n_checks++;
    if (low != lat[d]) begin
      n_fail++;
      $display("FAIL %s busy cycles: got %0d want %0d", nm, low, lat[d]);
    end
    n_checks++;
    if (got_err !== e_err) begin
      n_fail++;
      $display("FAIL %s err: got %b want %b (addr %h op %0d)", nm, got_err, e_err, addr, op);
    end
    n_checks++;
    if (got_rd !== e_rd) begin
      n_fail++;
      $display("FAIL %s rdata: got %h want %h (addr %h op %0d)", nm, got_rd, e_rd, addr, op);
    end
    @(negedge clk);
    n_checks++;
    if (rvld[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pulse width: resp_valid got %b want 0", nm, rvld[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1; sel = 0; req_valid = 0; req_we = 0;
    req_op = 0; req_addr = 0; req_wdata = 0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (rvld[d] !== 1'b0 || rerr[d] !== 1'b0 || rdat(d) !== 32'h0) begin
        n_fail++;
        $display("FAIL reset outputs dut%0d: got v=%b e=%b r=%h want 0", d, rvld[d], rerr[d], rdat(d));
      end
    end
    reset = 0;
    mdl.delete();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (rdy[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset ready dut%0d: got %b want 1", d, rdy[d]);
      end
    end
  endtask

  task automatic test_basic();
    bit [31:0] r; bit e;
    access(0, 1, 0, 32'h10, 32'h1234_5678, "basic_st", r, e);
    access(0, 0, 0, 32'h10, 32'h0, "basic_ld", r, e);
    n_checks++;
    if (r !== 32'h1234_5678 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL basic literal: got %h/%b want 12345678/0", r, e);
    end
  endtask

  task automatic test_lanes();
    bit [31:0] r; bit e;
    bit [2:0]  ops [5] = '{3'd0, 3'd3, 3'd4, 3'd1, 3'd2};
    bit [31:0] ads [5] = '{32'h20, 32'h23, 32'h23, 32'h20, 32'h20};
    bit [31:0] exs [5] = '{32'h8000_BEEF, 32'hFFFF_FF80, 32'h0000_0080,
                           32'hFFFF_BEEF, 32'h0000_BEEF};
    access(0, 1, 0, 32'h20, 32'h0, "lane_clr", r, e);
    access(0, 1, 3, 32'h23, 32'h0000_0080, "lane_sb", r, e);
    access(0, 1, 1, 32'h20, 32'h0000_BEEF, "lane_sh", r, e);
    for (int i = 0; i < 5; i++) begin
      access(0, 0, ops[i], ads[i], 32'h0, "lane_ld", r, e);
      n_checks++;
      if (r !== exs[i] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL lane literal %0d: got %h/%b want %h/0", i, r, e, exs[i]);
      end
    end
  endtask

  task automatic test_errors();
    bit [31:0] r; bit e;
    bit [31:0] ads [5] = '{32'h22, 32'h21, 32'h20, 32'h0FFC, 32'h2000};
    bit [2:0]  ops [5] = '{3'd0, 3'd1, 3'd6, 3'd0, 3'd0};
    bit        wes [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int        dut [5] = '{0, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      access(dut[i], wes[i], ops[i], ads[i], 32'hFFFF_FFFF, "err", r, e);
      n_checks++;
      if (e !== 1'b1 || r !== 32'h0) begin
        n_fail++;
        $display("FAIL err literal %0d: got %h/%b want 0/1", i, r, e);
      end
    end
    access(0, 0, 0, 32'h20, 32'h0, "err_nowrite", r, e);
    n_checks++;
    if (r !== 32'h8000_BEEF) begin
      n_fail++;
      $display("FAIL err nowrite: got %h want 8000beef", r);
    end
  endtask

  task automatic test_boundary();
    bit [31:0] r; bit e;
    access(0, 1, 0, 32'hFFC, 32'hA5A5_A5A5, "bnd_st", r, e);
    access(0, 0, 0, 32'hFFC, 32'h0, "bnd_ld", r, e);
    n_checks++;
    if (r !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL bnd top: got %h want a5a5a5a5", r);
    end
    access(0, 0, 0, 32'h000, 32'h0, "bnd_zero", r, e);
    n_checks++;
    if (r !== 32'h0) begin
      n_fail++;
      $display("FAIL bnd word0: got %h want 0", r);
    end
    access(0, 0, 0, 32'h1000, 32'h0, "bnd_past", r, e);
    n_checks++;
    if (e !== 1'b1) begin
      n_fail++;
      $display("FAIL bnd past end err: got %b want 1", e);
    end
  endtask

  task automatic test_hold_valid();
    bit [31:0] ca [3];
    bit [31:0] cd [3];
    bit [31:0] r;
    bit e;
    int npulse = 0;
    sel = 1; req_we = 1; req_op = 0;
    for (int c = 0; c < 20; c++) begin
      req_valid = (c <= 10);
      req_addr  = 32'h1000 + 4 * $urandom_range(0, 1023);
      req_wdata = $urandom;
      if (c % 5 == 0 && c <= 10) begin
        ca[c/5] = req_addr;
        cd[c/5] = req_wdata;
      end
      @(posedge clk);
      @(negedge clk);
      if (rvld[1] === 1'b1) begin
        n_checks++;
        if (c != 4 + 5 * npulse) begin
          n_fail++;
          $display("FAIL hold pulse %0d time: got %0d want %0d", npulse, c, 4 + 5 * npulse);
        end
        n_checks++;
        if (rerr[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL hold pulse %0d err: got %b want 0", npulse, rerr[1]);
        end
        npulse++;
      end
    end
    req_valid = 0;
    n_checks++;
    if (npulse != 3) begin
      n_fail++;
      $display("FAIL hold pulse count: got %0d want 3", npulse);
    end
    for (int i = 0; i < 3; i++)
      model(1, 1, 0, ca[i], cd[i], e, r);
    for (int i = 0; i < 3; i++)
      access(1, 0, 0, ca[i], 32'h0, "hold_ld", r, e);
  endtask

  task automatic test_random();
    bit [31:0] r, addr;
    bit e;
    bit [2:0] op;
    int d;
    for (int i = 0; i < 60; i++) begin
      d    = ($urandom_range(0, 1) == 0) ? 0 : 2;
      op   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                         : 3'($urandom_range(0, 4));
      addr = ($urandom_range(0, 9) == 0) ? $urandom
                                         : 32'($urandom_range(0, 63));
      access(d, 1'($urandom_range(0, 1)), op, addr, $urandom, "random", r, e);
    end
  endtask

  task automatic test_reset_midop();
    bit [31:0] r; bit e;
    bit saw = 0;
    access(2, 1, 0, 32'h40, 32'h1111_1111, "abort_pre", r, e);
    sel = 2; req_valid = 1; req_we = 1; req_op = 0;
    req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(posedge clk);
    #1 reset = 1;
    #1;
    n_checks++;
    if (rvld[2] !== 1'b0 || rdat2 !== 32'h0) begin
      n_fail++;
      $display("FAIL abort async reset: got v=%b r=%h want 0/0", rvld[2], rdat2);
    end
    repeat (2) begin
      @(negedge clk);
      saw |= (rvld[2] === 1'b1);
    end
    reset = 0;
    mdl.delete();
    repeat (5) begin
      @(negedge clk);
      saw |= (rvld[2] === 1'b1);
    end
    n_checks++;
    if (saw) begin
      n_fail++;
      $display("FAIL abort resp_valid: got 1 want 0");
    end
    n_checks++;
    if (rdy[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort ready: got %b want 1", rdy[2]);
    end
    access(2, 0, 0, 32'h40, 32'h0, "abort_ld", r, e);
    n_checks++;
    if (r !== 32'h0) begin
      n_fail++;
      $display("FAIL abort load: got %h want 0", r);
    end
  endtask

  initial begin
    clk = 0;
    reset = 1;
    sel = 0;
    req_valid = 0;
    req_we = 0;
    req_op = 0;
    req_addr = 0;
    req_wdata = 0;
    test_reset();
    test_basic();
    test_lanes();
    test_errors();
    test_boundary();
    test_hold_valid();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
